hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It tracks in-flight destination registers and result readiness (Tnew) through E/M/W. From these it generates the D-stage stall and the forwarding-mux selects for the D-stage and E-stage operand muxes. It also owns the mult/div busy counter that stalls HI/LO users and back-to-back md starts.

---
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: tracks in-flight destinations
// through E/M/W and produces the D-stage stall, forwarding selects and mult/div busy.
module hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic [4:0] D_dst,
    input  logic [1:0] D_Tnew,
    input  logic       D_link,
    input  logic [1:0] D_md_start,
    input  logic       D_md_use,
    output logic       stall,
    output logic [2:0] rsMUXop,
    output logic [2:0] rtMUXop,
    output logic [2:0] E_rsMUXop,
    output logic [2:0] E_rtMUXop,
    output logic       md_busy
);

    localparam logic [2:0] SEL_GPR   = 3'b000;
    localparam logic [2:0] SEL_WDATA = 3'b001;
    localparam logic [2:0] SEL_MDATA = 3'b010;
    localparam logic [2:0] SEL_EPC8  = 3'b011;
    localparam logic [2:0] SEL_MPC8  = 3'b100;

    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
        logic       link;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] mdStart;
    } eStage_t;

    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
        logic       link;
    } mStage_t;

    eStage_t    eStage_q, eStage_d;
    mStage_t    mStage_q, mStage_d;
    logic [4:0] wDst_q;
    logic [3:0] mdCnt_q, mdCnt_d;

    logic stallRs, stallRt, mdBusy;

    // Youngest matching stage decides; a match in E is never forwarded from E itself
    // except for link values, the stall (or the E-stage mux) covers the rest.
    function automatic logic [2:0] fwdSel(input logic [4:0] src, input logic useE,
                                          input eStage_t e, input mStage_t m,
                                          input logic [4:0] wDst);
        logic [2:0] sel;
        sel = SEL_GPR;
        if (src == 5'd0)
            sel = SEL_GPR;
        else if (useE && e.dst == src)
            sel = e.link ? SEL_EPC8 : SEL_GPR;
        else if (m.dst == src)
            sel = m.link ? SEL_MPC8 : ((m.tnew == 2'd0) ? SEL_MDATA : SEL_GPR);
        else if (wDst == src)
            sel = SEL_WDATA;
        return sel;
    endfunction

    function automatic logic srcStall(input logic [4:0] src, input logic [1:0] tuse,
                                      input eStage_t e, input mStage_t m);
        logic hit;
        hit = 1'b0;
        if (src == 5'd0)
            hit = 1'b0;
        else if (e.dst == src)
            hit = (e.tnew > tuse);
        else if (m.dst == src)
            hit = (m.tnew > tuse);
        return hit;
    endfunction

    assign stallRs = srcStall(D_rs, D_Tuse_rs, eStage_q, mStage_q);
    assign stallRt = srcStall(D_rt, D_Tuse_rt, eStage_q, mStage_q);
    assign mdBusy  = (mdCnt_q != 4'd0) || (eStage_q.mdStart != 2'b00);

    assign md_busy   = mdBusy;
    assign stall     = stallRs | stallRt | (D_md_use & mdBusy) | ((D_md_start != 2'b00) & mdBusy);
    assign rsMUXop   = fwdSel(D_rs, 1'b1, eStage_q, mStage_q, wDst_q);
    assign rtMUXop   = fwdSel(D_rt, 1'b1, eStage_q, mStage_q, wDst_q);
    assign E_rsMUXop = fwdSel(eStage_q.rs, 1'b0, eStage_q, mStage_q, wDst_q);
    assign E_rtMUXop = fwdSel(eStage_q.rt, 1'b0, eStage_q, mStage_q, wDst_q);

    always_comb begin
        eStage_d = '0;
        if (!stall) begin
            eStage_d.dst     = D_dst;
            eStage_d.tnew    = D_Tnew;
            eStage_d.link    = D_link;
            eStage_d.rs      = D_rs;
            eStage_d.rt      = D_rt;
            eStage_d.mdStart = D_md_start;
        end

        mStage_d.dst  = eStage_q.dst;
        mStage_d.link = eStage_q.link;
        mStage_d.tnew = (eStage_q.tnew == 2'd0) ? 2'd0 : eStage_q.tnew - 2'd1;

        // The counter is loaded as the mult/div leaves E; until then E.mdStart holds busy.
        mdCnt_d = mdCnt_q;
        if (eStage_q.mdStart == 2'b01)
            mdCnt_d = 4'(MULT_CYC);
        else if (eStage_q.mdStart == 2'b10)
            mdCnt_d = 4'(DIV_CYC);
        else if (mdCnt_q != 4'd0)
            mdCnt_d = mdCnt_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            eStage_q <= '0;
            mStage_q <= '0;
            wDst_q   <= '0;
            mdCnt_q  <= '0;
        end else begin
            eStage_q <= eStage_d;
            mStage_q <= mStage_d;
            wDst_q   <= mStage_q.dst;
            mdCnt_q  <= mdCnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios followed by random traffic,
// all checked against an age-based model of the instructions in flight.
module tb_hazard_ctrl;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, D_dst;
    logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew, D_md_start;
    logic       D_link, D_md_use;
    logic       stall, md_busy;
    logic [2:0] rsMUXop, rtMUXop, E_rsMUXop, E_rtMUXop;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
        .D_dst(D_dst), .D_Tnew(D_Tnew), .D_link(D_link),
        .D_md_start(D_md_start), .D_md_use(D_md_use),
        .stall(stall), .rsMUXop(rsMUXop), .rtMUXop(rtMUXop),
        .E_rsMUXop(E_rsMUXop), .E_rtMUXop(E_rtMUXop), .md_busy(md_busy)
    );

    // Model: each in-flight instruction keeps its original Tnew; its age (0=E, 1=M, 2=W)
    // gives the remaining latency, and the mult/div unit is free after an absolute cycle.
    typedef struct {
        int dst;
        int tnew;
        int link;
        int rs;
        int rt;
        int md;
    } instr_t;

    instr_t pipe [3];
    int     cycleNo;
    int     busyUntil;

    function automatic int remaining(int age);
        return (pipe[age].tnew > age) ? pipe[age].tnew - age : 0;
    endfunction

    function automatic int expSel(int src, int firstAge);
        if (src == 0) return 0;
        for (int k = firstAge; k < 3; k++) begin
            if (pipe[k].dst == src) begin
                if (k == 0) return pipe[k].link ? 3 : 0;
                if (k == 1) return pipe[k].link ? 4 : ((remaining(1) == 0) ? 2 : 0);
                return 1;
            end
        end
        return 0;
    endfunction

    function automatic int expSrcStall(int src, int tuse);
        if (src == 0) return 0;
        for (int k = 0; k < 3; k++)
            if (pipe[k].dst == src) return (remaining(k) > tuse) ? 1 : 0;
        return 0;
    endfunction

    function automatic int expMdBusy();
        return (cycleNo <= busyUntil) ? 1 : 0;
    endfunction

    function automatic int expStall();
        int s;
        s = expSrcStall(int'(D_rs), int'(D_Tuse_rs)) | expSrcStall(int'(D_rt), int'(D_Tuse_rt));
        if ((D_md_use || D_md_start != 2'b00) && expMdBusy() == 1) s = 1;
        return s;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
        busyUntil = -1;
    endtask

    task automatic modelEdge();
        int st;
        st = expStall();
        cycleNo++;
        if (reset) begin
            modelReset();
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (st == 1)
                pipe[0] = '{default: 0};
            else
                pipe[0] = '{int'(D_dst), int'(D_Tnew), int'(D_link), int'(D_rs), int'(D_rt), int'(D_md_start)};
            if (pipe[0].md == 1) busyUntil = cycleNo + MULT_CYC;
            else if (pipe[0].md == 2) busyUntil = cycleNo + DIV_CYC;
        end
    endtask

    task automatic checkVal(string tag, logic [31:0] observed, logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, observed, expected, cycleNo);
        end
    endtask

    task automatic checkOutput();
        checkVal("stall", 32'(stall), expStall());
        checkVal("md_busy", 32'(md_busy), expMdBusy());
        checkVal("rsMUXop", 32'(rsMUXop), expSel(int'(D_rs), 0));
        checkVal("rtMUXop", 32'(rtMUXop), expSel(int'(D_rt), 0));
        checkVal("E_rsMUXop", 32'(E_rsMUXop), expSel(pipe[0].rs, 1));
        checkVal("E_rtMUXop", 32'(E_rtMUXop), expSel(pipe[0].rt, 1));
    endtask

    task automatic applyStimulus(int rs, int rt, int tuseRs, int tuseRt, int dst,
                                 int tnew, int link, int md, int mdUse);
        D_rs       = 5'(rs);
        D_rt       = 5'(rt);
        D_Tuse_rs  = 2'(tuseRs);
        D_Tuse_rt  = 2'(tuseRt);
        D_dst      = 5'(dst);
        D_Tnew     = 2'(tnew);
        D_link     = 1'(link);
        D_md_start = 2'(md);
        D_md_use   = 1'(mdUse);
    endtask

    task automatic sampleAndCheck();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic advance();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic step();
        sampleAndCheck();
        advance();
    endtask

    task automatic countStall(output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            sampleAndCheck();
            if (stall !== 1'b1) break;
            n++;
            advance();
        end
        checkVal("md_busy_after_stall", 32'(md_busy), 0);
        advance();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n;
        int kind, tr, tt, rsv, rtv;

        cycleNo = 0;
        modelReset();
        reset = 1'b1;
        applyStimulus(0, 0, 3, 3, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        sampleAndCheck();
        checkVal("reset_stall", 32'(stall), 0);
        checkVal("reset_md_busy", 32'(md_busy), 0);
        checkVal("reset_rsMUXop", 32'(rsMUXop), 0);
        checkVal("reset_E_rtMUXop", 32'(E_rtMUXop), 0);
        advance();
        reset = 1'b0;

        // ALU result needed by a branch in D
        applyStimulus(2, 3, 3, 3, 1, 1, 0, 0, 0);
        step();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        sampleAndCheck();
        checkVal("alu_br_stall0", 32'(stall), 1);
        checkVal("alu_br_rs0", 32'(rsMUXop), 0);
        advance();
        sampleAndCheck();
        checkVal("alu_br_stall1", 32'(stall), 0);
        checkVal("alu_br_rs1", 32'(rsMUXop), 3'b010);
        advance();

        // Load-use
        applyStimulus(0, 0, 1, 3, 8, 2, 0, 0, 0);
        step();
        applyStimulus(8, 0, 1, 3, 9, 1, 0, 0, 0);
        sampleAndCheck();
        checkVal("ld_use_stall0", 32'(stall), 1);
        advance();
        sampleAndCheck();
        checkVal("ld_use_stall1", 32'(stall), 0);
        checkVal("ld_use_rs1", 32'(rsMUXop), 0);
        advance();
        applyStimulus(0, 0, 3, 3, 0, 0, 0, 0, 0);
        sampleAndCheck();
        checkVal("ld_use_E_rs", 32'(E_rsMUXop), 3'b001);
        advance();

        // Link forwarding from E then M
        applyStimulus(0, 0, 3, 3, 31, 0, 1, 0, 0);
        step();
        applyStimulus(31, 0, 0, 3, 0, 0, 0, 0, 0);
        sampleAndCheck();
        checkVal("jal_E_stall", 32'(stall), 0);
        checkVal("jal_E_rs", 32'(rsMUXop), 3'b011);
        advance();
        sampleAndCheck();
        checkVal("jal_M_rs", 32'(rsMUXop), 3'b100);
        advance();

        // Register zero and youngest-stage priority
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        sampleAndCheck();
        checkVal("zero_rs", 32'(rsMUXop), 0);
        checkVal("zero_stall", 32'(stall), 0);
        advance();
        applyStimulus(0, 0, 3, 3, 5, 1, 0, 0, 0);
        step();
        step();
        applyStimulus(0, 5, 3, 1, 6, 1, 0, 0, 0);
        sampleAndCheck();
        checkVal("prio_stall", 32'(stall), 0);
        checkVal("prio_rt", 32'(rtMUXop), 0);
        advance();
        applyStimulus(0, 0, 3, 3, 0, 0, 0, 0, 0);
        sampleAndCheck();
        checkVal("prio_E_rt", 32'(E_rtMUXop), 3'b010);
        advance();

        // mult then mflo
        applyStimulus(1, 2, 1, 1, 0, 0, 0, 1, 0);
        step();
        applyStimulus(0, 0, 3, 3, 2, 1, 0, 0, 1);
        countStall(n);
        checkVal("mult_mflo_stall_cycles", n, 1 + MULT_CYC);

        // div then div
        applyStimulus(1, 2, 1, 1, 0, 0, 0, 2, 0);
        step();
        countStall(n);
        checkVal("div_div_stall_cycles", n, 1 + DIV_CYC);

        // Reset in the middle of a multiply
        applyStimulus(0, 0, 3, 3, 0, 0, 0, 0, 0);
        repeat (DIV_CYC + 2) step();
        applyStimulus(1, 2, 1, 1, 0, 0, 0, 1, 0);
        step();
        applyStimulus(0, 0, 3, 3, 0, 0, 0, 0, 0);
        step();
        step();
        reset = 1'b1;
        sampleAndCheck();
        checkVal("md_busy_before_reset", 32'(md_busy), 1);
        advance();
        reset = 1'b0;
        sampleAndCheck();
        checkVal("md_busy_after_reset", 32'(md_busy), 0);
        advance();

        // Reset with pending matches in E, M and W
        applyStimulus(0, 0, 3, 3, 4, 1, 0, 0, 0);
        repeat (3) step();
        applyStimulus(4, 4, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        sampleAndCheck();
        checkVal("rst_pend_stall", 32'(stall), 0);
        checkVal("rst_pend_rs", 32'(rsMUXop), 0);
        checkVal("rst_pend_rt", 32'(rtMUXop), 0);
        advance();

        // Random traffic over a small register set to provoke frequent matches
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            kind = $urandom_range(0, 9);
            tr   = $urandom_range(0, 2);
            tt   = $urandom_range(0, 2);
            rsv  = $urandom_range(0, 4);
            rtv  = $urandom_range(0, 4);
            if (rsv == 4) rsv = 31;
            if (rtv == 4) rtv = 31;
            if (kind == 0)
                applyStimulus(rsv, rtv, (tr == 2) ? 3 : tr, (tt == 2) ? 3 : tt, 31, 0, 1, 0, 0);
            else
                applyStimulus(rsv, rtv, (tr == 2) ? 3 : tr, (tt == 2) ? 3 : tt,
                              $urandom_range(0, 3), (kind < 3) ? 2 : 1, 0,
                              (kind == 3) ? $urandom_range(0, 2) : 0,
                              ($urandom_range(0, 5) == 0) ? 1 : 0);
            step();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
